// File: rtl/rvfi_commit_tracker.sv
// rtl/rvfi_commit_tracker.sv - multi-channel RVFI commit checker with sticky error flags and IPC window
module rvfi_commit_tracker #(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned CNT_W      = 64,
   parameter int unsigned TIMEOUT    = 10000,
   parameter logic [31:0] START_INST = 32'h00102013,
   parameter logic [31:0] STOP_INST  = 32'h00202013
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    valid_i,
   input  logic [NUM_CH*64-1:0] order_i,
   input  logic [NUM_CH*32-1:0] inst_i,
   input  logic [NUM_CH*32-1:0] pc_rdata_i,
   input  logic [NUM_CH*32-1:0] pc_wdata_i,
   output logic                 halt_o,
   output logic                 error_o,
   output logic [4:0]           errcode_o,
   output logic [CNT_W-1:0]     cycle_count_o,
   output logic [CNT_W-1:0]     inst_count_o,
   output logic                 window_done_o
);

   localparam int unsigned WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [31:0] HALT_INST = 32'h0000006f;

   typedef enum logic [1:0] {PRE, MEASURE, DONE} win_e;

   win_e             win_q, win_d;
   logic [63:0]      exp_order_q, exp_order_d;
   logic [31:0]      last_pc_q, last_pc_d;
   logic             have_pc_q, have_pc_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             halt_q, halt_d;
   logic             error_q, error_d;
   logic [4:0]       errcode_q, errcode_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ins_q, ins_d;
   logic             done_q, done_d;

   logic [3:0]  k, n_above, n_upto, n_between;
   logic        ord_err, pc_err, pack_err, halt_hit, wd_hit, ok;
   logic        start_hit, stop_hit;
   int          start_idx, stop_idx;
   logic [31:0] prev_wdata;

   // Comparisons are written as "ok only if equal" so an X operand counts as a mismatch.
   always_comb begin
      k          = '0;
      ord_err    = 1'b0;
      pc_err     = 1'b0;
      halt_hit   = 1'b0;
      start_hit  = 1'b0;
      stop_hit   = 1'b0;
      start_idx  = 0;
      stop_idx   = 0;
      ok         = 1'b0;
      prev_wdata = '0;
      last_pc_d  = last_pc_q;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (valid_i[i]) begin
            k  = k + 4'd1;
            ok = 1'b0;
            if (order_i[64*i +: 64] == exp_order_q + 64'(i)) ok = 1'b1;
            if (!ok) ord_err = 1'b1;
            ok = 1'b0;
            if (i == 0) begin
               if (!have_pc_q || pc_rdata_i[31:0] == last_pc_q) ok = 1'b1;
            end else if (pc_rdata_i[32*i +: 32] == prev_wdata) begin
               ok = 1'b1;
            end
            if (!ok) pc_err = 1'b1;
            if (pc_rdata_i[32*i +: 32] == pc_wdata_i[32*i +: 32] ||
                inst_i[32*i +: 32] == HALT_INST) halt_hit = 1'b1;
            last_pc_d = pc_wdata_i[32*i +: 32];
            if (!start_hit && inst_i[32*i +: 32] == START_INST) begin
               start_hit = 1'b1;
               start_idx = i;
            end
            if (!stop_hit && inst_i[32*i +: 32] == STOP_INST) begin
               stop_hit = 1'b1;
               stop_idx = i;
            end
         end
         prev_wdata = pc_wdata_i[32*i +: 32];
      end
   end

   always_comb begin
      n_above   = '0;
      n_upto    = '0;
      n_between = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (valid_i[i]) begin
            if (i > start_idx) n_above = n_above + 4'd1;
            if (i <= stop_idx) n_upto = n_upto + 4'd1;
            if (i > start_idx && i <= stop_idx) n_between = n_between + 4'd1;
         end
      end
   end

   // A set bit with a clear bit below it means valid is not a contiguous low run.
   assign pack_err = |(valid_i & (valid_i + NUM_CH'(1)));

   always_comb begin
      exp_order_d = exp_order_q + 64'(k);
      have_pc_d   = have_pc_q | (k != 4'd0);
      halt_d      = halt_q | halt_hit;
      if (k != 4'd0 || halt_q) begin
         wd_d = '0;
      end else if (wd_q != WD_W'(TIMEOUT)) begin
         wd_d = wd_q + WD_W'(1);
      end else begin
         wd_d = wd_q;
      end
      wd_hit    = (TIMEOUT != 0) && (wd_d == WD_W'(TIMEOUT));
      errcode_d = errcode_q | {(k != 4'd0) && halt_q, wd_hit, pack_err, pc_err, ord_err};
      error_d   = |errcode_d;

      win_d = win_q;
      cyc_d = cyc_q;
      ins_d = ins_q;
      case (win_q)
         PRE: begin
            cyc_d = cyc_q + CNT_W'(1);
            ins_d = ins_q + CNT_W'(k);
            if (start_hit) begin
               if (stop_hit && stop_idx > start_idx) begin
                  win_d = DONE;
                  cyc_d = CNT_W'(1);
                  ins_d = CNT_W'(n_between);
               end else begin
                  win_d = MEASURE;
                  cyc_d = '0;
                  ins_d = CNT_W'(n_above);
               end
            end
         end
         MEASURE: begin
            cyc_d = cyc_q + CNT_W'(1);
            if (stop_hit) begin
               ins_d = ins_q + CNT_W'(n_upto);
               win_d = DONE;
            end else begin
               ins_d = ins_q + CNT_W'(k);
            end
         end
         DONE:    ;
         default: win_d = PRE;
      endcase
      done_d = (win_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q       <= PRE;
         exp_order_q <= '0;
         last_pc_q   <= '0;
         have_pc_q   <= 1'b0;
         wd_q        <= '0;
         halt_q      <= 1'b0;
         error_q     <= 1'b0;
         errcode_q   <= '0;
         cyc_q       <= '0;
         ins_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         win_q       <= win_d;
         exp_order_q <= exp_order_d;
         last_pc_q   <= last_pc_d;
         have_pc_q   <= have_pc_d;
         wd_q        <= wd_d;
         halt_q      <= halt_d;
         error_q     <= error_d;
         errcode_q   <= errcode_d;
         cyc_q       <= cyc_d;
         ins_q       <= ins_d;
         done_q      <= done_d;
      end
   end

   assign halt_o        = halt_q;
   assign error_o       = error_q;
   assign errcode_o     = errcode_q;
   assign cycle_count_o = cyc_q;
   assign inst_count_o  = ins_q;
   assign window_done_o = done_q;

endmodule
